schk_tx: RTL and testbench



---
 rtl/schk_tx.sv | 104 ++++++++++
 tb/tb_schk_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/schk_tx.sv
// Serial frame transmitter: a fixed sync header, then DW payload bits, then GAP idle zeros.
// Its TXD output feeds the DIN input of the sync checker.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for START; TXD=0, also the DONE cycle
// ST_HDR   | shifting out SYNC, MSB first, 8 bits
// ST_DATA  | shifting out the latched payload, DW bits
// ST_GAP   | driving TXD=0 for GAP bits
module schk_tx #(
    parameter logic [7:0] SYNC = 8'b1110_1000,
    parameter int          DW   = 8,
    parameter int          GAP  = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [DW-1:0] DIN,
    output logic          TXD,
    output logic          TXV,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t        state;
    logic [5:0]    cnt;
    logic [DW-1:0] sreg;
    logic          fin;

    // The outputs are derived from the state that held before each edge.
    // This puts the first header bit one cycle after the accepting edge and
    // the DONE pulse in the first cycle after returning to IDLE. That same
    // edge can already accept the next START.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
            sreg  <= '0;
            fin   <= 1'b0;
            TXD   <= 1'b0;
            TXV   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            fin  <= 1'b0;
            DONE <= fin;
            TXD  <= 1'b0;
            TXV  <= 1'b0;
            BUSY <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_HDR;
                        cnt   <= 6'd7;
                        sreg  <= DIN;
                    end
                end
                ST_HDR: begin
                    TXD <= SYNC[cnt[2:0]];
                    TXV <= 1'b1;
                    if (cnt == 6'd0) begin
                        state <= ST_DATA;
                        cnt   <= 6'(DW - 1);
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                ST_DATA: begin
                    TXD  <= sreg[DW-1];
                    TXV  <= 1'b1;
                    sreg <= sreg << 1;
                    if (cnt == 6'd0) begin
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                            fin   <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                            cnt   <= 6'(GAP - 1);
                        end
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 6'd0) begin
                        state <= ST_IDLE;
                        fin   <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_schk_tx.sv
// Directed bench for schk_tx: a default instance (DW=8, GAP=2) and a short-frame instance (DW=4, GAP=0).
// Each cycle is checked against a hand-built frame template.
module tb_schk_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd, txv, busy, done;

    logic       start4 = 1'b0;
    logic [3:0] din4 = 4'h0;
    logic       txd4, txv4, busy4, done4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    schk_tx #(.DW(8), .GAP(2)) u_dut (
        .CLK(CLK), .RST(RST), .START(start), .DIN(din),
        .TXD(txd), .TXV(txv), .BUSY(busy), .DONE(done)
    );

    schk_tx #(.DW(4), .GAP(0)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(start4), .DIN(din4),
        .TXD(txd4), .TXV(txv4), .BUSY(busy4), .DONE(done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle; afterwards we sit in the cycle that follows that edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected {TXD,TXV,BUSY,DONE} in cycle k+p of a frame accepted at edge k.
    function automatic logic [3:0] exp_vec(input int p, input logic [31:0] d,
                                           input int dw, input int gap);
        logic [7:0] s;
        s = 8'b1110_1000;
        if (p >= 1 && p <= 8)
            return {s[8-p], 3'b110};
        else if (p > 8 && p <= 8 + dw)
            return {d[8+dw-p], 3'b110};
        else if (p > 8 + dw && p <= 8 + dw + gap)
            return 4'b0010;
        else if (p == 9 + dw + gap)
            return 4'b0001;
        return 4'b0000;
    endfunction

    // One frame on the default instance. With inject set, a second START with
    // new DIN arrives mid-frame and DIN is disturbed again later.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit inject);
        int ndone;
        ndone = 0;
        din   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            chk($sformatf("%s_c%0d", tag, i), {28'd0, txd, txv, busy, done},
                {28'd0, exp_vec(i, {24'd0, d}, 8, 2)});
            if (done) ndone++;
            start = inject && (i == 4);
            if (inject && i == 4) din = 8'hFF;
            if (inject && i == 9) din = 8'h00;
        end
        chk({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle_c%0d", i), {28'd0, txd, txv, busy, done}, 32'd0);
            chk($sformatf("idle4_c%0d", i), {28'd0, txd4, txv4, busy4, done4}, 32'd0);
        end

        run_frame("f5a", 8'h5A, 1'b0);
        run_frame("ign", 8'h5A, 1'b1);
        run_frame("sync", 8'hE8, 1'b0);

        // START held high: frames accepted at k, k+19, k+38.
        din   = 8'hC3;
        start = 1'b1;
        tick();
        for (int i = 1; i <= 57; i++) begin
            tick();
            chk($sformatf("held_c%0d", i), {28'd0, txd, txv, busy, done},
                {28'd0, exp_vec((i - 1) % 19 + 1, 32'h0000_00C3, 8, 2)});
            if (i == 56) start = 1'b0;
        end
        tick();
        chk("held_after", {28'd0, txd, txv, busy, done}, 32'd0);

        // Reset mid-payload aborts the frame, then a fresh frame follows.
        din   = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("pre_rst_c%0d", i), {28'd0, txd, txv, busy, done},
                {28'd0, exp_vec(i, 32'h0000_005A, 8, 2)});
        end
        RST = 1'b1;
        tick();
        chk("rst_abort", {28'd0, txd, txv, busy, done}, 32'd0);
        RST = 1'b0;
        run_frame("post_rst", 8'h3C, 1'b0);

        // Short frame with no gap, START held: 13-cycle period.
        din4   = 4'b1001;
        start4 = 1'b1;
        tick();
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk($sformatf("g0_c%0d", i), {28'd0, txd4, txv4, busy4, done4},
                {28'd0, exp_vec((i - 1) % 13 + 1, 32'h0000_0009, 4, 0)});
            if (i == 25) start4 = 1'b0;
        end
        tick();
        chk("g0_after", {28'd0, txd4, txv4, busy4, done4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
